// File: rtl/alu_pkg.sv
// Shared ALU control types, opcode/select constants and the opcode decoder
// used by the decode stage in front of the ALU.
package alu_pkg;

    typedef struct packed {
        logic       pre_x_en;
        logic       pre_x_sub;
        logic       pre_y_en;
        logic       pre_y_sub;
        logic       mul_x_en;
        logic [2:0] mul_x_sel;
        logic       mul_y_en;
        logic [2:0] mul_y_sel;
        logic       post_en;
        logic       post_sub;
    } alu_ctrl_t;

    localparam logic [2:0] SEL_X0  = 3'd0;
    localparam logic [2:0] SEL_X1  = 3'd1;
    localparam logic [2:0] SEL_SQ  = 3'd2;
    localparam logic [2:0] SEL_C   = 3'd3;
    localparam logic [2:0] SEL_ONE = 3'd4;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_DOT2   = 8'h01;
    localparam logic [7:0] OP_MAC    = 8'h02;
    localparam logic [7:0] OP_MULX   = 8'h03;
    localparam logic [7:0] OP_MULY   = 8'h04;
    localparam logic [7:0] OP_SUMSQ  = 8'h05;
    localparam logic [7:0] OP_DIFSQ  = 8'h06;
    localparam logic [7:0] OP_DET2   = 8'h07;
    localparam logic [7:0] OP_SQDIFF = 8'h08;
    localparam logic [7:0] OP_ADD    = 8'h09;
    localparam logic [7:0] OP_PMUL   = 8'h0A;
    localparam logic [7:0] OP_PMULB  = 8'h0B;
    localparam logic [7:0] OP_MACC   = 8'h0C;
    localparam logic [7:0] OP_CROSS  = 8'h0D;
    localparam logic [7:0] OP_LERPX  = 8'h0E;
    localparam logic [7:0] OP_LERPY  = 8'h0F;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op <= OP_LERPY);
    endfunction

    // Unlisted opcodes (NOP and anything illegal) fall back to the default ctrl.
    function automatic alu_ctrl_t decode_op(input logic [7:0] op);
        alu_ctrl_t c;
        c           = '0;
        c.mul_x_sel = SEL_X1;
        c.mul_y_sel = SEL_X1;
        case (op)
            OP_DOT2, OP_MAC, OP_MULX, OP_MULY, OP_MACC: begin
                c.mul_x_en = 1'b1;
                c.mul_y_en = 1'b1;
                c.post_en  = 1'b1;
            end
            OP_SUMSQ, OP_DIFSQ: begin
                c.pre_x_en  = 1'b1;
                c.pre_y_en  = 1'b1;
                c.pre_x_sub = (op == OP_DIFSQ);
                c.pre_y_sub = (op == OP_DIFSQ);
                c.mul_x_en  = 1'b1;
                c.mul_y_en  = 1'b1;
                c.mul_x_sel = SEL_ONE;
                c.mul_y_sel = SEL_ONE;
            end
            OP_DET2, OP_CROSS: begin
                c.mul_x_en = 1'b1;
                c.mul_y_en = 1'b1;
                c.post_en  = 1'b1;
                c.post_sub = 1'b1;
            end
            OP_SQDIFF: begin
                c.pre_x_en  = 1'b1;
                c.pre_x_sub = 1'b1;
                c.pre_y_en  = 1'b1;
                c.pre_y_sub = 1'b1;
                c.mul_x_en  = 1'b1;
                c.mul_y_en  = 1'b1;
                c.mul_x_sel = SEL_SQ;
                c.mul_y_sel = SEL_SQ;
                c.post_en   = 1'b1;
                c.post_sub  = 1'b1;
            end
            OP_ADD: begin
                c.pre_x_en = 1'b1;
                c.post_en  = 1'b1;
            end
            OP_PMUL, OP_PMULB: begin
                c.mul_x_en = 1'b1;
                c.mul_y_en = 1'b1;
            end
            OP_LERPX: begin
                c.mul_x_en  = 1'b1;
                c.mul_x_sel = SEL_ONE;
                c.pre_y_en  = 1'b1;
                c.pre_y_sub = 1'b1;
                c.mul_y_en  = 1'b1;
                c.mul_y_sel = SEL_C;
                c.post_en   = 1'b1;
            end
            OP_LERPY: begin
                c.pre_x_en  = 1'b1;
                c.pre_x_sub = 1'b1;
                c.mul_x_en  = 1'b1;
                c.mul_x_sel = SEL_C;
                c.mul_y_en  = 1'b1;
                c.mul_y_sel = SEL_ONE;
                c.post_en   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with a synchronous flush. Head word is read straight
// from the array so a pushed entry is visible on the cycle after the push.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Buffered ALU decode stage: decodes RX commands, routes operands, queues them
// for the ALU and drops/counts illegal opcodes.
module decode_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [7:0]           op,
    input  logic [DATA_W-1:0]    a1,
    input  logic [DATA_W-1:0]    a2,
    input  logic [DATA_W-1:0]    b1,
    input  logic [DATA_W-1:0]    b2,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output alu_ctrl_t            ctrl,
    output logic [DATA_W-1:0]    x0,
    output logic [DATA_W-1:0]    x1,
    output logic [DATA_W-1:0]    y0,
    output logic [DATA_W-1:0]    y1,
    output logic                 err_illegal,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CTRL_W  = $bits(alu_ctrl_t);
    localparam int ENTRY_W = CTRL_W + 4 * DATA_W;

    logic                 legal;
    alu_ctrl_t            dec_ctrl;
    logic [DATA_W-1:0]    r_x0, r_x1, r_y0, r_y1;
    logic [ENTRY_W-1:0]   push_data;
    logic [ENTRY_W-1:0]   head_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    logic                 err_illegal_q, err_illegal_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        legal    = is_legal_op(op);
        dec_ctrl = decode_op(op);
        r_x0     = a1;
        r_x1     = a2;
        r_y0     = b1;
        r_y1     = b2;
        // Cross-lane routing for the pair-multiply and cross-product forms.
        if (op == OP_PMULB) begin
            r_y1 = a2;
        end else if (op == OP_CROSS) begin
            r_x1 = b2;
            r_y1 = a2;
        end
    end

    assign push_data = {dec_ctrl, r_x0, r_x1, r_y0, r_y1};

    // rx_ready only looks at registered occupancy and flush, never cmd_ready.
    assign rx_ready  = !fifo_full && !flush;
    assign push      = rx_valid && rx_ready && legal;
    assign cmd_valid = !fifo_empty;
    assign pop       = cmd_valid && cmd_ready;

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {ctrl, x0, x1, y0, y1} = head_data;

    // rx_ready already folds in flush, so a flushed illegal offer is ignored.
    always_comb begin
        err_illegal_d = rx_valid && rx_ready && !legal;
        err_count_d   = err_count_q;
        if (err_illegal_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            err_illegal_q <= err_illegal_d;
            err_count_q   <= err_count_d;
        end
    end

    assign err_illegal = err_illegal_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed scenarios followed by random traffic.
module tb_decode_pipe;
    import alu_pkg::*;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 2;
    localparam int ERR_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    typedef struct {
        logic [13:0]       ctrl;
        logic [DATA_W-1:0] x0, x1, y0, y1;
        logic [7:0]        op;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic                 rx_valid = 1'b0;
    logic                 rx_ready;
    logic [7:0]           op = 8'h00;
    logic [DATA_W-1:0]    a1 = '0, a2 = '0, b1 = '0, b2 = '0;
    logic                 cmd_valid;
    logic                 cmd_ready = 1'b0;
    alu_ctrl_t            ctrl;
    logic [DATA_W-1:0]    x0, x1, y0, y1;
    logic                 err_illegal;
    logic [ERR_CNT_W-1:0] err_count;

    decode_pipe #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .op          (op),
        .a1          (a1),
        .a2          (a2),
        .b1          (b1),
        .b2          (b2),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ctrl        (ctrl),
        .x0          (x0),
        .x1          (x1),
        .y0          (y0),
        .y1          (y1),
        .err_illegal (err_illegal),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   occ      = 0;
    bit   exp_err  = 0;
    int   exp_cnt  = 0;
    bit   armed    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, want);
        end
    endtask

    // Reference: each field described by the set of opcodes that enable it.
    function automatic exp_t model_entry(input logic [7:0] o, input logic [DATA_W-1:0] ia1,
                                         input logic [DATA_W-1:0] ia2, input logic [DATA_W-1:0] ib1,
                                         input logic [DATA_W-1:0] ib2);
        exp_t e;
        int   n;
        bit   pxe, pxs, pye, pys, mxe, mye, pe, ps;
        int   mxs, mys;
        n   = int'(o);
        pxe = n inside {5, 6, 8, 9, 15};
        pxs = n inside {6, 8, 15};
        pye = n inside {5, 6, 8, 14};
        pys = n inside {6, 8, 14};
        mxe = n inside {[1:8], [10:15]};
        mye = mxe;
        pe  = n inside {[1:4], [7:9], [12:15]};
        ps  = n inside {7, 8, 13};
        mxs = (n == 5 || n == 6 || n == 14) ? 4 : (n == 8) ? 2 : (n == 15) ? 3 : 1;
        mys = (n == 5 || n == 6 || n == 15) ? 4 : (n == 8) ? 2 : (n == 14) ? 3 : 1;
        e.ctrl = {pxe, pxs, pye, pys, mxe, 3'(mxs), mye, 3'(mys), pe, ps};
        e.x0   = ia1;
        e.x1   = (n == 13) ? ib2 : ia2;
        e.y0   = ib1;
        e.y1   = (n == 11 || n == 13) ? ia2 : ib2;
        e.op   = o;
        return e;
    endfunction

    // Model update at each active edge, from bench-side state only.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            occ     = 0;
            exp_err = 0;
            exp_cnt = 0;
            armed   = 1;
        end else begin
            bit acc, pop_m, lgl;
            acc     = rx_valid && (occ < DEPTH) && !flush;
            lgl     = (op < 8'h10);
            pop_m   = cmd_ready && (occ > 0);
            exp_err = acc && !lgl;
            if (exp_err && exp_cnt < CNT_MAX) exp_cnt++;
            if (flush) begin
                exp_q.delete();
                occ = 0;
            end else begin
                if (acc && lgl) exp_q.push_back(model_entry(op, a1, a2, b1, b2));
                occ = occ + ((acc && lgl) ? 1 : 0) - (pop_m ? 1 : 0);
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires the head on a pop.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("rx_ready", 64'(rx_ready), 64'((occ < DEPTH) && !flush));
            chk("cmd_valid", 64'(cmd_valid), 64'(occ != 0));
            chk("err_illegal", 64'(err_illegal), 64'(exp_err));
            chk("err_count", 64'(err_count), 64'(exp_cnt));
            if (occ != 0 && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q[0];
                chk($sformatf("ctrl op%0h", e.op),
                    64'({ctrl.pre_x_en, ctrl.pre_x_sub, ctrl.pre_y_en, ctrl.pre_y_sub,
                         ctrl.mul_x_en, ctrl.mul_x_sel, ctrl.mul_y_en, ctrl.mul_y_sel,
                         ctrl.post_en, ctrl.post_sub}), 64'(e.ctrl));
                chk($sformatf("x0 op%0h", e.op), 64'(x0), 64'(e.x0));
                chk($sformatf("x1 op%0h", e.op), 64'(x1), 64'(e.x1));
                chk($sformatf("y0 op%0h", e.op), 64'(y0), 64'(e.y0));
                chk($sformatf("y1 op%0h", e.op), 64'(y1), 64'(e.y1));
                if (cmd_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] o, input logic [DATA_W-1:0] ia1,
                       input logic [DATA_W-1:0] ia2, input logic [DATA_W-1:0] ib1,
                       input logic [DATA_W-1:0] ib2, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        rx_valid  = v;
        op        = o;
        a1        = ia1;
        a2        = ia2;
        b1        = ib1;
        b2        = ib2;
        cmd_ready = rdy;
        flush     = fl;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, '0, '0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2, 1'b1);

        // Cross-product routing
        cyc(1'b1, 8'h0D, 8'd3, 8'd4, 8'd5, 8'd6, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Fill with back-pressure, offer a third, then drain in order
        cyc(1'b1, 8'h05, 8'd10, 8'd11, 8'd12, 8'd13, 1'b0, 1'b0);
        cyc(1'b1, 8'h06, 8'd20, 8'd21, 8'd22, 8'd23, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h01, 8'd30, 8'd31, 8'd32, 8'd33, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Single illegal opcode, then saturation of the error counter
        cyc(1'b1, 8'h42, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 1'b0);
        idle(2, 1'b1);
        for (int i = 0; i < 300; i++)
            cyc(1'b1, 8'($urandom_range(16, 255)), '0, '0, '0, '0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Back-to-back stream of every legal opcode
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 8'(i), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Flush with a simultaneous offer while two entries are queued
        cyc(1'b1, 8'h01, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 8'd5, 8'd6, 8'd7, 8'd8, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Random traffic with occasional flush, illegal ops and reset
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] o;
            o = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, o, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        idle(4, 1'b1);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
